// File: rtl/ins_mem_loader.sv
// Instruction-memory loader: takes 32-bit words over a valid/ready stream and writes
// them big-endian, one byte per cycle, starting at a latched base address.
module ins_mem_loader #(
  parameter int MEM_DEPTH = 241
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic [7:0]  BaseAddr,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  input  logic        word_last,
  output logic        word_ready,
  output logic [7:0]  ByteAddr,
  output logic [7:0]  ByteData,
  output logic        nWR,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  WordCount
);

  typedef enum logic [2:0] {IDLE, WAIT_WORD, WRITE, DONE, ERROR} state_e;

  localparam logic [8:0] LAST_ADDR = 9'(MEM_DEPTH - 1);

  state_e      state_q, state_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [31:0] word_q, word_d;
  logic        last_q, last_d;
  logic [1:0]  k_q, k_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        err_q, err_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;

  logic        in_write;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_byte;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      k_q     <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      word_q  <= word_d;
      last_q  <= last_d;
      k_q     <= k_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    wr_addr = ptr_q + {6'd0, k_q};
    case (k_q)
      2'd0:    wr_byte = word_q[31:24];
      2'd1:    wr_byte = word_q[23:16];
      2'd2:    wr_byte = word_q[15:8];
      default: wr_byte = word_q[7:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    word_d  = word_q;
    last_d  = last_q;
    k_d     = k_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = BaseAddr;
          wcnt_d  = '0;
          err_d   = 1'b0;
          state_d = WAIT_WORD;
        end
      end
      WAIT_WORD: begin
        if (word_valid) begin
          word_d = word_data;
          last_d = word_last;
          // Widened compare so a pointer near 255 cannot wrap into a legal range.
          if (({1'b0, ptr_q} + 9'd3) > LAST_ADDR) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end else begin
            k_d     = 2'd0;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        addr_d = wr_addr;
        data_d = wr_byte;
        k_d    = k_q + 2'd1;
        if (k_q == 2'd3) begin
          ptr_d   = ptr_q + 8'd4;
          wcnt_d  = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;
          state_d = last_q ? DONE : WAIT_WORD;
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_write   = (state_q == WRITE);
  // Gating with nRST kills the strobe in the reset cycle itself, so a reset
  // mid-word leaves no further byte written.
  assign nWR        = !(in_write && nRST);
  assign ByteAddr   = in_write ? wr_addr : addr_q;
  assign ByteData   = in_write ? wr_byte : data_q;
  assign word_ready = (state_q == WAIT_WORD);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign err        = err_q;
  assign WordCount  = wcnt_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed bench for ins_mem_loader: logs every byte write and checks against hand-computed vectors.
module tb_ins_mem_loader;

  logic        CLK = 1'b0;
  logic        nRST, start, word_valid, word_last;
  logic [7:0]  BaseAddr;
  logic [31:0] word_data;
  logic        word_ready, nWR, busy, done, err;
  logic [7:0]  ByteAddr, ByteData, WordCount;

  int n_vec = 0;
  int n_err = 0;
  int n_done, n_rdy, cyc;
  logic [7:0] wa[$];
  logic [7:0] wd[$];
  int         wc[$];

  ins_mem_loader #(.MEM_DEPTH(241)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .BaseAddr(BaseAddr),
    .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
    .word_ready(word_ready), .ByteAddr(ByteAddr), .ByteData(ByteData), .nWR(nWR),
    .busy(busy), .done(done), .err(err), .WordCount(WordCount)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    cyc++;
    if (nWR === 1'b0) begin
      wa.push_back(ByteAddr);
      wd.push_back(ByteData);
      wc.push_back(cyc);
    end
    if (done === 1'b1) n_done++;
    if (word_ready === 1'b1) n_rdy++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_log();
    wa.delete(); wd.delete(); wc.delete();
    n_done = 0; n_rdy = 0;
  endtask

  task automatic do_start(input logic [7:0] b);
    start = 1'b1; BaseAddr = b;
    tick();
    start = 1'b0;
  endtask

  // Holds word_valid high and returns just after the edge that accepts the word.
  task automatic send(input logic [31:0] d, input logic l);
    int t;
    word_valid = 1'b1; word_data = d; word_last = l;
    t = 0;
    while (t < 20) begin
      @(negedge CLK);
      if (word_ready === 1'b1) break;
      t++;
    end
    if (t == 20) chk("ready_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (t < 60) begin
      @(negedge CLK);
      if (busy === 1'b0) break;
      t++;
    end
    if (t == 60) chk("idle_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [7:0] base,
                          input logic [31:0] d);
    logic [7:0] eb;
    for (int k = 0; k < 4; k++) begin
      eb = d[31-8*k -: 8];
      if (idx*4 + k < wa.size()) begin
        chk({tag, "_addr"}, wa[idx*4+k], base + 8'(k));
        chk({tag, "_data"}, wd[idx*4+k], eb);
      end else begin
        chk({tag, "_missing"}, 32'd0, 32'd1);
      end
    end
  endtask

  initial begin
    nRST = 1'b0; start = 1'b0; word_valid = 1'b0; word_last = 1'b0;
    BaseAddr = '0; word_data = '0; cyc = 0;
    clr_log();
    tick(); tick();
    nRST = 1'b1;
    @(negedge CLK);
    chk("rst_nwr", nWR, 1'b1);
    chk("rst_ready", word_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_wcnt", WordCount, 8'd0);
    chk("rst_baddr", ByteAddr, 8'd0);
    chk("rst_bdata", ByteData, 8'd0);
    tick();

    // single word at address 0
    clr_log();
    do_start(8'd0);
    send(32'h8C010004, 1'b1);
    word_valid = 1'b0;
    wait_idle();
    chk("w1_nwrites", wa.size(), 4);
    chk_word("w1", 0, 8'd0, 32'h8C010004);
    if (wc.size() == 4) chk("w1_consec", wc[3] - wc[0], 3);
    chk("w1_done", n_done, 1);
    chk("w1_wcnt", WordCount, 8'd1);

    // three back-to-back words with valid held high
    clr_log();
    do_start(8'd16);
    send(32'h11223344, 1'b0);
    send(32'h55667788, 1'b0);
    send(32'h99AABBCC, 1'b1);
    word_valid = 1'b0;
    wait_idle();
    chk("w3_nwrites", wa.size(), 12);
    chk_word("w3a", 0, 8'd16, 32'h11223344);
    chk_word("w3b", 1, 8'd20, 32'h55667788);
    chk_word("w3c", 2, 8'd24, 32'h99AABBCC);
    chk("w3_rdy", n_rdy, 3);
    if (wc.size() == 12) chk("w3_gap", wc[4] - wc[3], 2);
    chk("w3_done", n_done, 1);
    chk("w3_wcnt", WordCount, 8'd3);

    // word ending exactly on the last location
    clr_log();
    do_start(8'd237);
    send(32'hDEADBEEF, 1'b1);
    word_valid = 1'b0;
    wait_idle();
    chk("edge_nwrites", wa.size(), 4);
    chk_word("edge", 0, 8'd237, 32'hDEADBEEF);
    chk("edge_done", n_done, 1);
    chk("edge_err", err, 1'b0);

    // one byte past the end: overflow
    clr_log();
    do_start(8'd238);
    send(32'hCAFEF00D, 1'b1);
    word_valid = 1'b0;
    wait_idle();
    chk("ovf_nwrites", wa.size(), 0);
    chk("ovf_err", err, 1'b1);
    chk("ovf_done", n_done, 0);
    chk("ovf_busy", busy, 1'b0);
    chk("ovf_wcnt", WordCount, 8'd0);
    tick(); tick();
    chk("ovf_sticky", err, 1'b1);

    // reset during the second byte of a word at address 8
    clr_log();
    do_start(8'd8);
    chk("start_clr_err", err, 1'b0);
    send(32'hA1B2C3D4, 1'b1);
    word_valid = 1'b0;
    tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    chk("mrst_nwrites", wa.size(), 1);
    if (wa.size() > 0) begin
      chk("mrst_addr", wa[0], 8'd8);
      chk("mrst_data", wd[0], 8'hA1);
    end
    chk("mrst_nwr", nWR, 1'b1);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_wcnt", WordCount, 8'd0);
    chk("mrst_baddr", ByteAddr, 8'd0);
    chk("mrst_bdata", ByteData, 8'd0);
    tick();

    // word_valid alone in IDLE, start+valid together, start while busy
    clr_log();
    word_valid = 1'b1; word_data = 32'hFFFFFFFF; word_last = 1'b1;
    tick(); tick(); tick();
    chk("idle_valid_busy", busy, 1'b0);
    start = 1'b1; BaseAddr = 8'd40;
    tick();
    start = 1'b0; word_valid = 1'b0;
    tick(); tick();
    chk("sv_busy", busy, 1'b1);
    chk("sv_ready", word_ready, 1'b1);
    chk("sv_nwrites", wa.size(), 0);
    start = 1'b1; BaseAddr = 8'd100;
    tick();
    start = 1'b0;
    send(32'h01020304, 1'b1);
    word_valid = 1'b0;
    wait_idle();
    chk("ign_nwrites", wa.size(), 4);
    chk_word("ign", 0, 8'd40, 32'h01020304);
    chk("ign_done", n_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
